// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package debounce_pkg;

   // Per-channel debounce FSM; encoding is fixed so waveforms read the same across builds.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } deb_state_e;

   localparam int unsigned DEFAULT_STABLE_TICKS = 3;
   localparam int unsigned DEFAULT_LONG_TICKS   = 20;

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: 2-flop synchroniser, tick-counting FSM, registered level and
// rise/fall pulses. Optional long-press pulse when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter int unsigned LONG_TICKS   = DEFAULT_LONG_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic btn_long
);

   localparam int unsigned CNT_W = $clog2(STABLE_TICKS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   if (STABLE_TICKS < 1) begin : g_bad_stable
      $error("STABLE_TICKS must be at least 1");
   end
   if (LONG_TICKS < 1) begin : g_bad_long
      $error("LONG_TICKS must be at least 1");
   end

   logic             sync1_q, sync2_q;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Debounce state, tick counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next state: a revert always beats a coincident tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            if (sync2_q) begin
               state_d = PEND_HI;
               cnt_d   = '0;
            end
         end
         STABLE_HI: begin
            if (!sync2_q) begin
               state_d = PEND_LO;
               cnt_d   = '0;
            end
         end
         PEND_HI: begin
            if (!sync2_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_HI;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PEND_LO: begin
            if (sync2_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_LO;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = STABLE_LO;
      endcase
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int unsigned LONG_W = $clog2(LONG_TICKS) + 1;
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);

   logic [LONG_W-1:0] lcnt_q, lcnt_d;
   logic              long_q, long_d;

   // Long-press counter and its registered one-shot pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         lcnt_d_unused_guard: begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
         end
      end
   end

   // Count ticks in STABLE_HI, freeze in PEND_LO (a revert resumes), clear while low.
   always_comb begin
      lcnt_d = lcnt_q;
      long_d = 1'b0;
      unique case (state_q)
         STABLE_HI: begin
            if (tick && (lcnt_q != LONG_MAX)) begin
               lcnt_d = lcnt_q + 1'b1;
               long_d = (lcnt_q == LONG_MAX - 1'b1);
            end
         end
         PEND_LO: begin
            if (state_d == STABLE_LO) begin
               lcnt_d = '0;
            end
         end
         default: lcnt_d = '0;
      endcase
   end

   assign btn_long = long_q;
`else
   assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer driven by the shared prescaler tick.
// Define DEBOUNCE_LONGPRESS_EN to build the per-channel long-press pulse; otherwise btn_long is 0.
module button_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter int unsigned LONG_TICKS   = DEFAULT_LONG_TICKS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] btn_rise,
   output logic [NUM_CH-1:0] btn_fall,
   output logic [NUM_CH-1:0] btn_long
);

   for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
      debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick      (tick),
         .btn_in    (btn_in[i]),
         .btn_level (btn_level[i]),
         .btn_rise  (btn_rise[i]),
         .btn_fall  (btn_fall[i]),
         .btn_long  (btn_long[i])
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: behavioural model checked every cycle, plus directed scenarios.
module tb_button_debounce;
   import debounce_pkg::*;

   localparam int NCH = 4;
   localparam int ST  = DEFAULT_STABLE_TICKS;
   localparam int LT  = DEFAULT_LONG_TICKS;
   localparam int TP  = 8;
`ifdef DEBOUNCE_LONGPRESS_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           tick = 1'b0;
   logic [NCH-1:0] btn_in = '0;
   logic [NCH-1:0] btn_level, btn_rise, btn_fall, btn_long;

   always #5 clk = ~clk;

   button_debounce #(
      .NUM_CH       (NCH),
      .STABLE_TICKS (ST),
      .LONG_TICKS   (LT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .btn_in    (btn_in),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .btn_long  (btn_long)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: the synced input must differ from the accepted level; ticks are counted from the
   // cycle after the difference is first seen, and the ST-th such tick accepts the new level.
   bit [NCH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_long;
   int           m_diff [NCH];
   int           m_tc   [NCH];
   int           m_hi   [NCH];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_long = '0;
         for (int c = 0; c < NCH; c++) begin
            m_diff[c] = 0; m_tc[c] = 0; m_hi[c] = 0;
         end
      end else begin
         m_rise = '0; m_fall = '0; m_long = '0;
         for (int c = 0; c < NCH; c++) begin
            bit s;
            s       = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_in[c];
            // Long press: ticks seen while accepted high and not in a release attempt.
            if (LONG_ON && m_lvl[c] && m_diff[c] == 0 && tick && m_hi[c] < LT) begin
               m_hi[c]++;
               if (m_hi[c] == LT) m_long[c] = 1'b1;
            end
            if (s == m_lvl[c]) begin
               m_diff[c] = 0;
               m_tc[c]   = 0;
            end else begin
               if (m_diff[c] > 0 && tick) m_tc[c]++;
               m_diff[c]++;
               if (m_tc[c] == ST) begin
                  m_lvl[c]  = s;
                  m_rise[c] = s;
                  m_fall[c] = !s;
                  m_diff[c] = 0;
                  m_tc[c]   = 0;
                  m_hi[c]   = 0;
               end
            end
         end
      end
   end

   bit run_cmp = 1'b0;

   always @(negedge clk) begin
      if (run_cmp) begin
         check("model_level", btn_level, m_lvl);
         check("model_rise", btn_rise, m_rise);
         check("model_fall", btn_fall, m_fall);
         check("model_long", btn_long, m_long);
      end
   end

   // Stimulus bookkeeping, all owned by the initial block.
   int cyc = 0;
   int ph = 0;
   int tmode = 0;       // 0: tick every TP cycles, 1: random ticks, 2: man_tick
   bit man_tick = 1'b0;
   int rise_c [NCH];
   int fall_c [NCH];
   int long_c [NCH];
   int last_rise [NCH];
   int last_long [NCH];

   task automatic clr_counts();
      for (int c = 0; c < NCH; c++) begin
         rise_c[c] = 0; fall_c[c] = 0; long_c[c] = 0; last_rise[c] = 0; last_long[c] = 0;
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         ph = (ph + 1) % TP;
         case (tmode)
            0:       tick = (ph == 0);
            1:       tick = ($urandom_range(0, 2) == 0);
            default: tick = man_tick;
         endcase
         @(negedge clk);
         cyc++;
         for (int c = 0; c < NCH; c++) begin
            if (btn_rise[c] === 1'b1) begin rise_c[c]++; last_rise[c] = cyc; end
            if (btn_fall[c] === 1'b1) fall_c[c]++;
            if (btn_long[c] === 1'b1) begin long_c[c]++; last_long[c] = cyc; end
         end
      end
   endtask

   task automatic man_ticks(input int n);
      man_tick = 1'b1;
      step(n);
      man_tick = 1'b0;
   endtask

   initial begin
      int gap;
      clr_counts();
      run_cmp = 1'b1;

      // Reset state.
      step(3);
      check("reset_level", btn_level, '0);
      check("reset_rise", btn_rise, '0);
      check("reset_fall", btn_fall, '0);
      check("reset_long", btn_long, '0);
      #2 rst_n = 1'b1;

      // Clean press on channel 0.
      tmode = 0;
      clr_counts();
      btn_in[0] = 1'b1;
      step(60);
      check("press_level", btn_level, 4'b0001);
      check_int("press_rise0", rise_c[0], 1);
      check_int("press_rise_others", rise_c[1] + rise_c[2] + rise_c[3], 0);

      // Bounce on channel 1: never stable long enough, then settles high.
      clr_counts();
      for (int i = 0; i < 8; i++) begin
         btn_in[1] = ~btn_in[1];
         step(5);
      end
      check_int("bounce_activity", rise_c[1] + fall_c[1], 0);
      btn_in[1] = 1'b1;
      step(60);
      check_int("bounce_rise1", rise_c[1], 1);
      check("bounce_level", btn_level, 4'b0011);

      // Revert on channel 2 in the same cycle a tick is sampled.
      tmode = 2;
      clr_counts();
      btn_in[2] = 1'b1;
      step(3);
      man_ticks(2);
      btn_in[2] = 1'b0;
      step(2);
      man_ticks(1);
      step(5);
      check_int("revert_rise2", rise_c[2], 0);
      btn_in[2] = 1'b1;
      step(3);
      man_ticks(2);
      step(2);
      check_int("revert_recount", rise_c[2], 0);
      man_ticks(1);
      step(2);
      check_int("revert_then_rise2", rise_c[2], 1);
      check("revert_level", btn_level, 4'b0111);

      // Release on channel 0: a short glitch is ignored, a real release falls.
      tmode = 0;
      clr_counts();
      btn_in[0] = 1'b0;
      step(10);
      btn_in[0] = 1'b1;
      step(40);
      check_int("short_release_fall0", fall_c[0], 0);
      btn_in[0] = 1'b0;
      step(60);
      check_int("release_fall0", fall_c[0], 1);
      check("release_level", btn_level, 4'b0110);

      // Long press on channel 3.
      clr_counts();
      btn_in[3] = 1'b1;
      step(300);
      check_int("long_count3", long_c[3], LONG_ON ? 1 : 0);
      gap = (long_c[3] > 0) ? (last_long[3] - last_rise[3]) : 0;
      check_int("long_gap3", gap, LONG_ON ? LT * TP : 0);
      btn_in[3] = 1'b0;
      step(60);

      // Reset while channel 0 is pending with two ticks counted.
      tmode = 2;
      clr_counts();
      btn_in[0] = 1'b1;
      step(3);
      man_ticks(2);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_level", btn_level, '0);
      check("midreset_rise", btn_rise, '0);
      step(2);
      #2 rst_n = 1'b1;
      step(3);
      man_ticks(2);
      step(2);
      check_int("midreset_no_early_rise", rise_c[0], 0);
      man_ticks(1);
      step(2);
      check_int("midreset_rise0", rise_c[0], 1);
      check("midreset_level_after", btn_level, 4'b0111);

      // Random stimulus with random ticks, then periodic ticks, occasional resets.
      for (int seg = 0; seg < 2; seg++) begin
         tmode = (seg == 0) ? 1 : 0;
         for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
               if ($urandom_range(0, (seg == 0) ? 9 : 19) == 0) btn_in[c] = ~btn_in[c];
            end
            if ($urandom_range(0, 1499) == 0) begin
               #2 rst_n = 1'b0;
               step(2);
               #2 rst_n = 1'b1;
            end
            step(1);
         end
      end

      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
